// File: rtl/seq_divider.sv
// Sequential restoring divider: 8-bit unsigned dividend by 4-bit unsigned divisor,
// one quotient bit per clock, with a divide-by-zero flag.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// CALC  | one restoring step per clock, dividend MSB first (one step for b=0)
// DONE  | single-cycle done pulse, results already loaded into q/r/dbz
module seq_divider (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] a,
   input  logic [3:0] b,
   output logic [7:0] q,
   output logic [3:0] r,
   output logic       busy,
   output logic       done,
   output logic       dbz
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t     state;
   logic [7:0] a_sh;
   logic [3:0] b_reg;
   logic [3:0] pr;
   logic [6:0] q_acc;
   logic [2:0] cnt;

   logic [4:0] pr_sh;
   logic [3:0] pr_nxt;
   logic       q_bit;

   // The stored remainder is always below b, so only the shifted value needs the 5th bit.
   always_comb begin
      pr_sh  = {pr, a_sh[7]};
      q_bit  = (pr_sh >= {1'b0, b_reg});
      pr_nxt = pr_sh[3:0];
      if (q_bit) begin
         pr_nxt = 4'(pr_sh - {1'b0, b_reg});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_sh  <= '0;
         b_reg <= '0;
         pr    <= '0;
         q_acc <= '0;
         cnt   <= '0;
         q     <= '0;
         r     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dbz   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_reg <= b;
                  pr    <= '0;
                  q_acc <= '0;
                  cnt   <= 3'd7;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               if (b_reg == 4'd0) begin
                  q     <= 8'hFF;
                  r     <= a_sh[3:0];
                  dbz   <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  a_sh  <= {a_sh[6:0], 1'b0};
                  pr    <= pr_nxt;
                  q_acc <= {q_acc[5:0], q_bit};
                  cnt   <= cnt - 3'd1;
                  // Terminal count: this is the 8th step, so publish the result.
                  if (cnt == 3'd0) begin
                     q     <= {q_acc, q_bit};
                     r     <= pr_nxt;
                     dbz   <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
